// File: rtl/pipe_adder_nbit.sv
// rtl/pipe_adder_nbit.sv - pipelined block-carry add/subtract unit with valid/ready flow control
// Optional signed saturation of the result is built in when PIPE_ADDER_SAT_EN is defined.
module pipe_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_o,
  output logic             ovf
);
  localparam int L = WIDTH / BLK;

  // Operand words travel right-justified: each stage consumes the low BLK bits of
  // a and b' and shifts its sum block in from the top, so after L stages the word
  // holds the complete sum in natural bit order.
  logic [WIDTH-1:0] src_w [L];
  logic [WIDTH-1:0] src_b [L];
  logic             src_c [L];
  logic             src_v [L];
  logic             vld   [L];
  logic [L:0]       load;
`ifdef PIPE_ADDER_SAT_EN
  logic             src_sat [L];
  assign src_sat[0] = sat;
`endif

  assign src_w[0] = a;
  assign src_b[0] = sub ? ~b : b;
  assign src_c[0] = sub | c_i;
  assign src_v[0] = in_valid;

  // A stage may load when it is empty or its successor is loading this cycle.
  always_comb begin
    load    = '0;
    load[L] = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      load[k] = !vld[k] || load[k+1];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [BLK:0]     bs;
    logic [WIDTH-1:0] nxt_w;

    assign bs = {1'b0, src_w[k][BLK-1:0]} + {1'b0, src_b[k][BLK-1:0]} + {{BLK{1'b0}}, src_c[k]};

    if (BLK == WIDTH) begin : g_whole
      assign nxt_w = bs[BLK-1:0];
    end else begin : g_split
      assign nxt_w = {bs[BLK-1:0], src_w[k][WIDTH-1:BLK]};
    end

    if (k < L - 1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] w_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (load[k]) begin
          v_q <= src_v[k];
        end
      end

      always_ff @(posedge clk) begin
        if (load[k] && src_v[k]) begin
          w_q <= nxt_w;
          b_q <= {{BLK{1'b0}}, src_b[k][WIDTH-1:BLK]};
          c_q <= bs[BLK];
        end
      end

`ifdef PIPE_ADDER_SAT_EN
      logic sat_q;
      always_ff @(posedge clk) begin
        if (load[k] && src_v[k]) begin
          sat_q <= src_sat[k];
        end
      end
      assign src_sat[k+1] = sat_q;
`endif

      assign vld[k]     = v_q;
      assign src_v[k+1] = v_q;
      assign src_w[k+1] = w_q;
      assign src_b[k+1] = b_q;
      assign src_c[k+1] = c_q;
    end else begin : g_last
      logic             a_msb;
      logic             b_msb;
      logic             ovf_n;
      logic [WIDTH-1:0] res;

      // Only the top block of a and b' remains here, so its MSB is the operand MSB.
      assign a_msb = src_w[k][BLK-1];
      assign b_msb = src_b[k][BLK-1];
      assign ovf_n = (a_msb == b_msb) && (bs[BLK-1] != a_msb);

      always_comb begin
        res = nxt_w;
`ifdef PIPE_ADDER_SAT_EN
        if (src_sat[k] && ovf_n) begin
          res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          c_o       <= 1'b0;
          ovf       <= 1'b0;
        end else if (load[k]) begin
          out_valid <= src_v[k];
          if (src_v[k]) begin
            sum <= res;
            c_o <= bs[BLK];
            ovf <= ovf_n;
          end
        end
      end

      assign vld[k] = out_valid;
    end
  end

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// tb/tb_pipe_adder_nbit.sv - self-checking bench for pipe_adder_nbit (16/4 and 8/8 builds)
module tb_pipe_adder_nbit;
  localparam int LAT = 4;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, c_i, sub, sat, out_valid, out_ready, c_o, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid8, in_ready8, c_i8, sub8, out_valid8, out_ready8, c_o8, ovf8;
  logic [7:0]  a8, b8, sum8;
`ifdef PIPE_ADDER_SAT_EN
  logic        sat8;
`endif

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_adder_nbit #(.WIDTH(16), .BLK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_i(c_i), .sub(sub),
`ifdef PIPE_ADDER_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_o(c_o), .ovf(ovf)
  );

  pipe_adder_nbit #(.WIDTH(8), .BLK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .c_i(c_i8), .sub(sub8),
`ifdef PIPE_ADDER_SAT_EN
    .sat(sat8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .c_o(c_o8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {c_o, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s, input logic st);
    int ua, ub, ur, sa, sb, sr, cin;
    logic [15:0] r;
    logic co, ov;
    ua = int'(x);
    ub = int'(y);
    sa = $signed(x);
    sb = $signed(y);
    cin = ci ? 1 : 0;
    if (s) begin
      ur = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub + cin;
      co = (ur > 65535);
      sr = sa + sb + cin;
    end
    r  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
    if (SAT_BUILD && st && ov) r = (sr > 0) ? 16'h7FFF : 16'h8000;
    return {co, ov, r};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s, input logic st, input logic [17:0] exp);
    int n;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a = x; b = y; c_i = ci; sub = s; sat = st;
    #1;
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 16) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_result"}, {14'd0, c_o, ovf, sum}, {14'd0, exp});
  endtask

  initial begin
    int sent, got, cyc, acc;
    logic seen, stale;
    logic [15:0] held;
    logic [17:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_i = 1'b0; sub = 1'b0; sat = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; c_i8 = 1'b0; sub8 = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    sat8 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {13'd0, out_valid, c_o, ovf, sum}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid8", {31'd0, out_valid8}, 32'd0);

    run_one("add_cin", 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2222});
    run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, {1'b0, 1'b0, 16'hFFFE});
    run_one("ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    run_one("ovf_sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1,
            {1'b0, 1'b1, SAT_BUILD ? 16'h7FFF : 16'h8000});
    run_one("ovf_sat_neg", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1,
            {1'b1, 1'b1, SAT_BUILD ? 16'h8000 : 16'h7FFF});

    // Single-stage build
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'hC8; b8 = 8'h64; c_i8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    #1;
    chk("w8_ready", {31'd0, in_ready8}, 32'd1);
    chk("w8_pre_valid", {31'd0, out_valid8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    chk("w8_valid", {31'd0, out_valid8}, 32'd1);
    chk("w8_result", {22'd0, c_o8, ovf8, sum8}, {22'd0, 1'b1, 1'b0, 8'h2C});

    // Backpressure: consumer stalled for 10 cycles
    acc = 0; seen = 1'b0; held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      a = 16'($urandom()); b = 16'($urandom()); c_i = 1'($urandom()); sub = 1'($urandom()); sat = 1'($urandom());
      #1;
      if (in_ready) begin
        exp_q.push_back(model(a, b, c_i, sub, sat));
        acc++;
      end
      if (out_valid && !seen) begin
        held = sum;
        seen = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_held_sum", {16'd0, sum}, {16'd0, held});
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("bp_drain", {14'd0, c_o, ovf, sum}, {14'd0, e});
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("bp_drain_done", exp_q.size(), 0);

    // Random stream with random consumer stalls
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 100);
      a = 16'($urandom()); b = 16'($urandom()); c_i = 1'($urandom()); sub = 1'($urandom()); sat = 1'($urandom());
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, c_i, sub, sat));
        sent++;
      end
      if (out_valid && out_ready) begin
        chk("stream_expected_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("stream", {14'd0, c_o, ovf, sum}, {14'd0, e});
        end
        got++;
      end
      cyc++;
    end
    chk("stream_count", got, 100);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Reset with three beats in flight
    run_one("pre_rst", 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2222});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a = 16'($urandom()); b = 16'($urandom()); c_i = 1'b0; sub = 1'b0; sat = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_flags", {30'd0, c_o, ovf}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      stale = stale | out_valid;
    end
    chk("post_rst_no_stale", {31'd0, stale}, 32'd0);
    run_one("post_rst", 16'h4321, 16'h1111, 1'b0, 1'b1, 1'b0, model(16'h4321, 16'h1111, 1'b0, 1'b1, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_adder_nbit.md
# pipe_adder_nbit

Parametrised, pipelined add/subtract unit; successor to the fixed 8-bit two-block adder in the ALU datapath. Operands are split into BLK-bit blocks and one block is resolved per pipeline stage, with the block carry registered between stages. Sustains one operation per cycle, uses a valid/ready handshake on both sides and stalls under backpressure without losing data. Sits between the ALU operand mux and the result writeback register.

## Interface

- WIDTH, 16, operand/result width; must be a multiple of BLK and at least BLK
- BLK, 4, block width; one block per stage; stages L = WIDTH/BLK
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_i  input  1  carry-in, used only when sub=0
- sub  input  1  0: a+b+c_i; 1: a+~b+1 (a-b)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- c_o  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  signed (two's-complement) overflow
- sat  input  1  present only with PIPE_ADDER_SAT_EN; 1 = saturate signed result

## Operation

- Beat accepted when in_valid && in_ready; a, b, sub, c_i (and sat) captured into stage 0.
- Stage k (0..L-1) adds block k of a and b' (b' = sub ? ~b : b) with the incoming carry; stage 0 carry-in = sub ? 1 : c_i.
- Each stage register holds: resolved low sum bits so far, unprocessed upper a/b' bits, block carry, valid bit, and mode bits. Already-resolved bits are carried forward unchanged.
- Final stage produces sum, c_o = carry out of block L-1, ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
- Flow control per stage: stage k loads when stage k is empty or stage k+1 loads (last stage: when out_ready). in_ready = stage 0 loads. This is a full-throughput elastic pipeline; no bubbles are inserted when out_ready stays high.
- A result held with out_valid=1 && out_ready=0 keeps sum/c_o/ovf stable until taken.
- Unsigned wrap-around is natural: 0xFFFF+1 gives 0x0000, c_o=1.
- BLK == WIDTH is legal: single stage, latency 1.

## Timing

- Latency: L cycles from the accepting edge to out_valid (WIDTH=16, BLK=4: 4 cycles).
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is combinational from out_ready and the stage valid bits; it has no path from in_valid.
- Reset (asynchronous, any time, including mid-operation): all stage valid bits clear, in-flight beats discarded; out_valid=0, sum=0, c_o=0, ovf=0; in_ready=1 after reset releases.
- Simultaneous accept and emit in the same cycle with a full pipeline is permitted and loses no data.
- Stage data registers need not be reset except the last stage outputs; valid bits must be reset.

## Configuration

- PIPE_ADDER_SAT_EN defined: sat port exists and is carried with the beat. If sat=1 and ovf=1, sum is clamped to 0x7FF..F when a[MSB]=0 and to 0x800..0 when a[MSB]=1. ovf and c_o still report raw values. sat=0 gives wrapped results.
- PIPE_ADDER_SAT_EN undefined: no sat port; sum always wraps. The clamp logic is absent.

## Test plan

- WIDTH=16, BLK=4: a=0x1234, b=0x0FED, sub=0, c_i=1 -> after 4 cycles sum=0x2222, c_o=0, ovf=0.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, c_o=1, ovf=0; a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_o=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; with PIPE_ADDER_SAT_EN and sat=1 -> sum=0x7FFF, ovf=1. a=0x8000, b=0x0001, sub=1, sat=1 -> sum=0x8000, ovf=1.
- Stream 100 random beats back-to-back with out_ready toggling randomly -> results emerge in order and match the reference model. With out_ready=0 for 10 cycles, in_ready drops after 4 beats are accepted and the held sum does not change.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and all outputs 0 immediately. After release, the first new beat appears exactly 4 cycles after it is accepted, with no stale output.
- WIDTH=8, BLK=8 (single stage): a=0xC8, b=0x64 -> after 1 cycle sum=0x2C, c_o=1.
